// File: rtl/rect_cmd_sequencer_pkg.sv
// Shared screen geometry, command bundle layout and sequencer state encoding
// for the rectangle command sequencer.
package rect_cmd_sequencer_pkg;

  localparam int unsigned SCREEN_W = 320;
  localparam int unsigned SCREEN_H = 240;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [8:0] w;
    logic [7:0] h;
    logic [2:0] colour;
  } rect_cmd_t;

  localparam int CMD_W = $bits(rect_cmd_t);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_WAIT  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/rect_cmd_sequencer_if.sv
// Command channel from game/control logic plus the start/done channel to the
// drawing engine; master is the environment, slave is the sequencer.
interface rect_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [8:0] cmd_x;
  logic [7:0] cmd_y;
  logic [8:0] cmd_w;
  logic [7:0] cmd_h;
  logic [2:0] cmd_colour;

  logic       rect_start;
  logic [8:0] rect_xstart;
  logic [7:0] rect_ystart;
  logic [8:0] rect_width;
  logic [7:0] rect_height;
  logic [2:0] rect_colour;
  logic       rect_done;

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour, rect_done,
    input  cmd_ready, rect_start, rect_xstart, rect_ystart, rect_width,
           rect_height, rect_colour
  );

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour, rect_done,
    output cmd_ready, rect_start, rect_xstart, rect_ystart, rect_width,
           rect_height, rect_colour
  );
endinterface

// File: rtl/rect_cmd_sequencer_cmd_fifo.sv
// Synchronous command FIFO; head entry is visible on rdata_o whenever the
// FIFO is non-empty.
module rect_cmd_sequencer_cmd_fifo
  import rect_cmd_sequencer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2,
  parameter int WIDTH  = CMD_W
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              push_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              pop_i,
  output logic [WIDTH-1:0]  rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   count_o
);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_d;

  // NOTE: storage has no reset; an entry is only read after count_q shows it was written.
  always_ff @(posedge clock) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  // NOTE: count_d gets its default first so every path assigns it and no latch is inferred.
  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      count_q <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == (ADDR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/rect_cmd_sequencer.sv
// Queues draw commands, clips each to the screen, and issues them one at a
// time to the drawing engine with a start/done handshake.
module rect_cmd_sequencer
  import rect_cmd_sequencer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic                 clock,
  input  logic                 resetn,
  rect_cmd_sequencer_if.slave  bus,
  output logic                 busy_o,
  output logic [ADDR_W:0]      queue_count_o,
  output logic                 cmd_dropped_o
);

  rect_cmd_t  wr_cmd;
  rect_cmd_t  head_cmd;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;

  seq_state_t state_q;
  logic       busy_q;
  logic       start_q;
  logic       dropped_q;
  logic [8:0] xstart_q;
  logic [7:0] ystart_q;
  logic [8:0] width_q;
  logic [7:0] height_q;
  logic [2:0] colour_q;

  assign wr_cmd = '{x: bus.cmd_x, y: bus.cmd_y, w: bus.cmd_w,
                    h: bus.cmd_h, colour: bus.cmd_colour};
  assign push   = bus.cmd_valid && !fifo_full;
  assign pop    = (state_q == ST_LOAD);

  rect_cmd_sequencer_cmd_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (CMD_W)
  ) u_cmd_fifo (
    .clock   (clock),
    .resetn  (resetn),
    .push_i  (push),
    .wdata_i (wr_cmd),
    .pop_i   (pop),
    .rdata_o (head_cmd),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (queue_count_o)
  );

  logic [9:0] avail_w;
  logic [9:0] avail_h;
  logic       drop;
  logic [8:0] clip_w;
  logic [7:0] clip_h;

  // Off-screen origins show up as a zero or negative (borrowed) remaining span.
  always_comb begin
    avail_w = 10'(SCREEN_W) - {1'b0, head_cmd.x};
    avail_h = 10'(SCREEN_H) - {2'b00, head_cmd.y};
    drop    = avail_w[9] || (avail_w == '0) ||
              (avail_h[9:8] != 2'b00) || (avail_h == '0) ||
              (head_cmd.w == '0) || (head_cmd.h == '0);
    clip_w  = ({1'b0, head_cmd.w} < avail_w) ? head_cmd.w : avail_w[8:0];
    clip_h  = ({2'b00, head_cmd.h} < avail_h) ? head_cmd.h : avail_h[7:0];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      start_q   <= 1'b0;
      dropped_q <= 1'b0;
      xstart_q  <= '0;
      ystart_q  <= '0;
      width_q   <= '0;
      height_q  <= '0;
      colour_q  <= '0;
    end else begin
      start_q   <= 1'b0;
      dropped_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state_q <= ST_LOAD;
            busy_q  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (drop) begin
            dropped_q <= 1'b1;
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
          end else begin
            xstart_q <= head_cmd.x;
            ystart_q <= head_cmd.y;
            width_q  <= clip_w;
            height_q <= clip_h;
            colour_q <= head_cmd.colour;
            start_q  <= 1'b1;
            state_q  <= ST_ISSUE;
          end
        end
        ST_ISSUE: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (bus.rect_done) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready   = !fifo_full;
  assign bus.rect_start  = start_q;
  assign bus.rect_xstart = xstart_q;
  assign bus.rect_ystart = ystart_q;
  assign bus.rect_width  = width_q;
  assign bus.rect_height = height_q;
  assign bus.rect_colour = colour_q;
  assign busy_o          = busy_q;
  assign cmd_dropped_o   = dropped_q;

endmodule

// File: tb/tb_rect_cmd_sequencer.sv
// Self-checking bench for rect_cmd_sequencer: directed vector table, corner
// sequences, and randomized traffic against a screen-clipping reference model.
module tb_rect_cmd_sequencer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic              clock = 1'b0;
  logic              resetn;
  logic              busy;
  logic [ADDR_W:0]   queue_count;
  logic              cmd_dropped;

  rect_cmd_sequencer_if bus ();

  rect_cmd_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock         (clock),
    .resetn        (resetn),
    .bus           (bus.slave),
    .busy_o        (busy),
    .queue_count_o (queue_count),
    .cmd_dropped_o (cmd_dropped)
  );

  always #5 clock = ~clock;

  typedef struct {
    int x, y, w, h, col;
    bit drop;
    int ex, ey, ew, eh;
  } vec_t;

  typedef struct {
    bit drop;
    int x, y, w, h, col;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  int   last_x = 0, last_y = 0, last_w = 0, last_h = 0, last_c = 0;
  vec_t vecs [10];
  exp_t model_q [$];
  exp_t got_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_cmd(input int x, input int y, input int w, input int h, input int col);
    bus.cmd_valid  = 1'b1;
    bus.cmd_x      = 9'(x);
    bus.cmd_y      = 8'(y);
    bus.cmd_w      = 9'(w);
    bus.cmd_h      = 8'(h);
    bus.cmd_colour = 3'(col);
  endtask

  // Reference clip: screen is 320x240; width/height limited to what remains on screen.
  function automatic exp_t ref_clip(input int x, input int y, input int w, input int h, input int col);
    exp_t e;
    e.drop = (x >= 320) || (y >= 240) || (w == 0) || (h == 0);
    e.x    = x;
    e.y    = y;
    e.w    = (w < 320 - x) ? w : 320 - x;
    e.h    = (h < 240 - y) ? h : 240 - y;
    e.col  = col;
    return e;
  endfunction

  task automatic check_rect(input string tag, input int x, input int y, input int w, input int h, input int c);
    check({tag, " xstart"}, bus.rect_xstart, x);
    check({tag, " ystart"}, bus.rect_ystart, y);
    check({tag, " width"},  bus.rect_width,  w);
    check({tag, " height"}, bus.rect_height, h);
    check({tag, " colour"}, bus.rect_colour, c);
  endtask

  // Push one command into an idle, empty block and follow it to completion.
  task automatic run_vec(input vec_t v, input string tag);
    drive_cmd(v.x, v.y, v.w, v.h, v.col);
    tick();
    bus.cmd_valid = 1'b0;
    check({tag, " count after push"}, queue_count, 1);
    check({tag, " busy after push"}, busy, 0);
    tick();
    check({tag, " busy in load"}, busy, 1);
    check({tag, " start in load"}, bus.rect_start, 0);
    tick();
    check({tag, " start"}, bus.rect_start, !v.drop);
    check({tag, " dropped"}, cmd_dropped, v.drop);
    check({tag, " count after pop"}, queue_count, 0);
    if (!v.drop) begin
      last_x = v.ex; last_y = v.ey; last_w = v.ew; last_h = v.eh; last_c = v.col;
    end
    check_rect(tag, last_x, last_y, last_w, last_h, last_c);
    if (v.drop) begin
      check({tag, " busy after drop"}, busy, 0);
    end else begin
      tick();
      check({tag, " start one cycle"}, bus.rect_start, 0);
      check({tag, " busy in wait"}, busy, 1);
      bus.rect_done = 1'b1;
      tick();
      bus.rect_done = 1'b0;
      check({tag, " busy after done"}, busy, 0);
      check_rect({tag, " held"}, last_x, last_y, last_w, last_h, last_c);
    end
  endtask

  task automatic record_start();
    exp_t g;
    if (bus.rect_start) begin
      g.drop = 1'b0;
      g.x = int'(bus.rect_xstart); g.y = int'(bus.rect_ystart);
      g.w = int'(bus.rect_width);  g.h = int'(bus.rect_height);
      g.col = int'(bus.rect_colour);
      got_q.push_back(g);
    end
  endtask

  task automatic observe_rnd();
    exp_t e;
    if (bus.rect_start || cmd_dropped) begin
      if (model_q.size() == 0) begin
        check("rnd event with empty model", {bus.rect_start, cmd_dropped}, 0);
      end else begin
        e = model_q.pop_front();
        check("rnd dropped", cmd_dropped, e.drop);
        check("rnd start", bus.rect_start, !e.drop);
        if (!e.drop) check_rect("rnd", e.x, e.y, e.w, e.h, e.col);
      end
    end
  endtask

  initial begin
    bit started;

    vecs[0] = '{10, 20, 30, 40, 5, 0, 10, 20, 30, 40};
    vecs[1] = '{300, 230, 50, 50, 2, 0, 300, 230, 20, 10};
    vecs[2] = '{0, 0, 320, 240, 7, 0, 0, 0, 320, 240};
    vecs[3] = '{320, 0, 5, 5, 1, 1, 0, 0, 0, 0};
    vecs[4] = '{5, 5, 0, 3, 3, 1, 0, 0, 0, 0};
    vecs[5] = '{319, 239, 511, 255, 1, 0, 319, 239, 1, 1};
    vecs[6] = '{100, 0, 5, 255, 4, 0, 100, 0, 5, 240};
    vecs[7] = '{5, 240, 5, 5, 6, 1, 0, 0, 0, 0};
    vecs[8] = '{0, 0, 1, 1, 0, 0, 0, 0, 1, 1};
    vecs[9] = '{511, 255, 5, 5, 2, 1, 0, 0, 0, 0};

    resetn = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_x = '0; bus.cmd_y = '0; bus.cmd_w = '0; bus.cmd_h = '0; bus.cmd_colour = '0;
    bus.rect_done = 1'b0;
    #12;
    check("reset ready", bus.cmd_ready, 1);
    check("reset busy", busy, 0);
    check("reset count", queue_count, 0);
    check("reset start", bus.rect_start, 0);
    check("reset dropped", cmd_dropped, 0);
    check_rect("reset", 0, 0, 0, 0, 0);
    resetn = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // rect_done in IDLE and during the ISSUE cycle must be ignored.
    bus.rect_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("done in idle busy", busy, 0);
      check("done in idle start", bus.rect_start, 0);
    end
    drive_cmd(50, 60, 7, 8, 6);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    check("done-ignore start", bus.rect_start, 1);
    tick();
    bus.rect_done = 1'b0;
    check("done in issue ignored", busy, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("waits for done", busy, 1);
    end
    bus.rect_done = 1'b1;
    tick();
    bus.rect_done = 1'b0;
    check("later done accepted", busy, 0);
    tick();

    // Fill: five pushes with the engine stalled, a sixth stalled, then drain in order.
    got_q.delete();
    for (int i = 0; i < 5; i++) begin
      check("fill ready before push", bus.cmd_ready, 1);
      drive_cmd(i * 10 + 1, i * 5 + 2, i + 3, i + 4, i);
      tick();
      record_start();
    end
    bus.cmd_valid = 1'b0;
    check("fill ready at full", bus.cmd_ready, 0);
    check("fill count at full", queue_count, 4);
    drive_cmd(99, 99, 9, 9, 7);
    for (int i = 0; i < 3; i++) begin
      tick();
      record_start();
      check("sixth push stalled ready", bus.cmd_ready, 0);
      check("sixth push stalled count", queue_count, 4);
    end
    bus.cmd_valid = 1'b0;
    bus.rect_done = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      record_start();
    end
    bus.rect_done = 1'b0;
    check("fill issue count", got_q.size(), 5);
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      check($sformatf("fill order %0d x", i), got_q[i].x, i * 10 + 1);
      check($sformatf("fill order %0d y", i), got_q[i].y, i * 5 + 2);
      check($sformatf("fill order %0d w", i), got_q[i].w, i + 3);
      check($sformatf("fill order %0d h", i), got_q[i].h, i + 4);
      check($sformatf("fill order %0d col", i), got_q[i].col, i);
    end
    check("fill drained count", queue_count, 0);
    check("fill drained busy", busy, 0);

    // Reset while waiting with three commands queued.
    for (int i = 0; i < 4; i++) begin
      drive_cmd(20 + i, 30 + i, 4, 4, i);
      tick();
    end
    bus.cmd_valid = 1'b0;
    check("pre-reset count", queue_count, 3);
    check("pre-reset busy", busy, 1);
    tick();
    #2;
    resetn = 1'b0;
    #1;
    check("mid reset count", queue_count, 0);
    check("mid reset busy", busy, 0);
    check("mid reset start", bus.rect_start, 0);
    check("mid reset ready", bus.cmd_ready, 1);
    check_rect("mid reset", 0, 0, 0, 0, 0);
    @(posedge clock);
    #3;
    resetn = 1'b1;
    started = 1'b0;
    bus.rect_done = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.rect_start) started = 1'b1;
    end
    bus.rect_done = 1'b0;
    check("no issue after reset", started, 0);
    last_x = 0; last_y = 0; last_w = 0; last_h = 0; last_c = 0;
    run_vec('{5, 5, 5, 5, 1, 0, 5, 5, 5, 5}, "post-reset");

    // Randomized traffic against the reference model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int x, y, w, h, c;
      bus.rect_done = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) begin
        x = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 330));
        y = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 245));
        w = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 400));
        h = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255));
        c = int'($urandom_range(0, 7));
        drive_cmd(x, y, w, h, c);
        if (bus.cmd_ready) model_q.push_back(ref_clip(x, y, w, h, c));
      end else begin
        bus.cmd_valid = 1'b0;
      end
      tick();
      observe_rnd();
    end
    bus.cmd_valid = 1'b0;
    bus.rect_done = 1'b1;
    for (int i = 0; i < 300 && model_q.size() > 0; i++) begin
      tick();
      observe_rnd();
    end
    check("rnd model drained", model_q.size(), 0);
    tick();
    tick();
    check("rnd final count", queue_count, 0);
    check("rnd final busy", busy, 0);
    bus.rect_done = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
